// File: rtl/xor_descrambler_16.sv
// Receive-side XOR descrambler: 16-bit words XORed with a Galois LFSR keystream, one registered output stage.
// Optional parity check on accepted words is built when DESCR_PARITY_EN is defined.
module xor_descrambler_16 #(
    parameter int unsigned         WIDTH = 16,
    parameter logic [WIDTH-1:0]    POLY  = 16'hB400,
    parameter logic [WIDTH-1:0]    SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef DESCR_PARITY_EN
    input  logic             in_par,
    output logic             par_err,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] word_cnt
);

    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic             accept;

    // A seed load steals the cycle so the new keystream never mixes with an in-flight accept.
    assign in_ready = !seed_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        lfsr_next = lfsr >> 1;
        if (lfsr[0]) begin
            lfsr_next = (lfsr >> 1) ^ POLY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr      <= SEED;
            word_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (seed_load) begin
                lfsr     <= (seed == '0) ? SEED : seed;
                word_cnt <= '0;
            end else if (accept) begin
                lfsr     <= lfsr_next;
                word_cnt <= word_cnt + 1'b1;
            end

            // Accept takes precedence over drain so back-to-back words flow with no bubble.
            if (accept) begin
                out_data  <= in_data ^ lfsr;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DESCR_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (seed_load) begin
            par_err <= 1'b0;
        end else if (accept && (in_par != (^in_data))) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_xor_descrambler_16.sv
// Self-checking bench for xor_descrambler_16: queue-based reference model plus literal keystream pins.
// Parity checks are included when DESCR_PARITY_EN is defined.
module tb_xor_descrambler_16;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] POLY = 16'hB400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seed_load;
    logic [15:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] word_cnt;
`ifdef DESCR_PARITY_EN
    logic        in_par;
    logic        par_err;
    logic        bad_par = 1'b0;
    assign in_par = (^in_data) ^ bad_par;
`endif

    int          checks = 0;
    int          errors = 0;
    bit          model_live = 1'b0;
    logic [15:0] m_key;
    logic [15:0] m_cnt;
    logic [15:0] exp_q[$];
    logic [15:0] plain_q[$];
    logic [15:0] tx_key;

    xor_descrambler_16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef DESCR_PARITY_EN
        .in_par    (in_par),
        .par_err   (par_err),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic ordy,
                                 input logic sl, input logic [15:0] sd);
        in_valid  = valid;
        in_data   = data;
        out_ready = ordy;
        seed_load = sl;
        seed      = sd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one plaintext word scrambled with the transmit-side keystream until the DUT takes it.
    task automatic sendWord(input logic [15:0] plain, input bit random_ready);
        int waited = 0;
        forever begin
            applyStimulus(1'b1, plain ^ tx_key, random_ready ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0, 16'h0);
            @(negedge clk);
            if (in_ready) begin
                plain_q.push_back(plain);
                tx_key = step(tx_key);
                tick();
                break;
            end
            tick();
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL send_timeout: got no accept, expected accept within 200 clks");
                break;
            end
        end
    endtask

    // Reference model: a FIFO of expected descrambled words plus the keystream and word count.
    always @(negedge clk) begin
        logic exp_valid;
        logic exp_ready;
        if (!rst_n) begin
            exp_q.delete();
            plain_q.delete();
            m_key = SEED;
            m_cnt = 16'h0;
        end else if (model_live) begin
            exp_valid = (exp_q.size() > 0);
            exp_ready = !seed_load && (!exp_valid || out_ready);
            checkOutput("in_ready", {15'h0, in_ready}, {15'h0, exp_ready});
            checkOutput("out_valid", {15'h0, out_valid}, {15'h0, exp_valid});
            if (exp_valid) checkOutput("out_data", out_data, exp_q[0]);
            checkOutput("word_cnt", word_cnt, m_cnt);
            if (exp_valid && out_ready) begin
                void'(exp_q.pop_front());
                if (plain_q.size() > 0) checkOutput("plaintext", out_data, plain_q.pop_front());
            end
            if (seed_load) begin
                m_key = (seed == 16'h0) ? SEED : seed;
                m_cnt = 16'h0;
            end else if (in_valid && exp_ready) begin
                exp_q.push_back(in_data ^ m_key);
                m_key = step(m_key);
                m_cnt = m_cnt + 16'h1;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        tick();
        tick();
        rst_n = 1'b1;
        model_live = 1'b1;
        tx_key = SEED;
        checkOutput("reset_out_valid", {15'h0, out_valid}, 16'h0);
        checkOutput("reset_out_data", out_data, 16'h0);
        checkOutput("reset_word_cnt", word_cnt, 16'h0);

        // Known keystream pins.
        applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0); tick();
        checkOutput("t1_word0", out_data, 16'hACE1);
        applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0); tick();
        checkOutput("t1_word1", out_data, 16'h1D8F);
        applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0); tick();
        checkOutput("t1_word2", out_data, 16'h7138);
        checkOutput("t1_word_cnt", word_cnt, 16'd3);
        for (int i = 0; i < 3; i++) tx_key = step(tx_key);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0); tick();

        // Random stream with random back-pressure.
        for (int i = 0; i < 1000; i++) sendWord(16'($urandom), 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        repeat (3) tick();
        checkOutput("t2_drained", 16'(plain_q.size()), 16'h0);

        // Stall with a pending word, then release into a back-to-back stream.
        sendWord(16'hBEEF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 16'h1357, 1'b0, 1'b0, 16'h0); tick();
            checkOutput("t3_in_ready_stall", {15'h0, in_ready}, 16'h0);
        end
        checkOutput("t3_out_valid_stall", {15'h0, out_valid}, 16'h1);
        for (int i = 0; i < 4; i++) begin
            sendWord(16'h1000 + 16'(i), 1'b0);
            checkOutput("t3_no_bubble", {15'h0, out_valid}, 16'h1);
        end
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        repeat (2) tick();

        // Zero seed load falls back to SEED and restarts the count.
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1, 16'h0000);
        #2;
        checkOutput("t4_in_ready_seed", {15'h0, in_ready}, 16'h0);
        tick();
        checkOutput("t4_cnt_cleared", word_cnt, 16'h0);
        tx_key = SEED;
        applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0); tick();
        checkOutput("t4_word0", out_data, 16'hACE1);
        checkOutput("t4_cnt", word_cnt, 16'h1);
        tx_key = step(tx_key);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0); tick();

        // Reset while a word is pending discards it.
        applyStimulus(1'b1, 16'h5A5A, 1'b1, 1'b0, 16'h0); tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0); tick(); tick();
        checkOutput("t5_pending", {15'h0, out_valid}, 16'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t5_out_valid", {15'h0, out_valid}, 16'h0);
        checkOutput("t5_out_data", out_data, 16'h0);
        checkOutput("t5_word_cnt", word_cnt, 16'h0);
        tx_key = SEED;
        applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0); tick();
        checkOutput("t5_restart", out_data, 16'hACE1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0); tick();

`ifdef DESCR_PARITY_EN
        checkOutput("t6_par_clear", {15'h0, par_err}, 16'h0);
        bad_par = 1'b1;
        applyStimulus(1'b1, 16'h0001, 1'b1, 1'b0, 16'h0); tick();
        bad_par = 1'b0;
        checkOutput("t6_par_set", {15'h0, par_err}, 16'h1);
        applyStimulus(1'b1, 16'h00FF, 1'b1, 1'b0, 16'h0); tick();
        checkOutput("t6_par_sticky0", {15'h0, par_err}, 16'h1);
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0, 16'h0); tick();
        checkOutput("t6_par_sticky1", {15'h0, par_err}, 16'h1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h1111); tick();
        checkOutput("t6_par_seed_clr", {15'h0, par_err}, 16'h0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0); tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
